nf10_axis_rr_arbiter: RTL
=========================

# nf10_axis_rr_arbiter

- Packet-granular round-robin arbiter that shares the 64-bit slave side of the nf10_axis_converter (64→256 upsizer) between up to 8 AXI4-Stream requesters, e.g. the 10G MAC RX paths.
- Sits directly upstream of the converter. It grants one input for a whole packet, passes that packet through unmodified, then rotates priority.
- Optionally stamps the source-port field of tuser so the downstream pipeline sees which input the packet came from.

## Interface
Parameters:
- C_NUM_PORTS, 4, number of requesters; legal range 2..8.
- C_DATA_WIDTH, 64, tdata width per port; tstrb width is C_DATA_WIDTH/8.
- C_TUSER_WIDTH, 128, tuser width per port.
- C_STAMP_SRC_PORT, 0, when 1 the output tuser[23:16] is overwritten with the one-hot code 8'b1 << (2*grant_index).

Ports:
- axi_aclk  in  1  the only clock; all logic on its rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  C_NUM_PORTS*C_DATA_WIDTH  packed per-port data; port i occupies slice i.
- s_axis_tstrb  in  C_NUM_PORTS*C_DATA_WIDTH/8  packed byte strobes.
- s_axis_tuser  in  C_NUM_PORTS*C_TUSER_WIDTH  packed sideband.
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
- s_axis_tlast  in  C_NUM_PORTS  per-port last.
- s_axis_tready  out  C_NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_DATA_WIDTH  to converter s_axis_tdata.
- m_axis_tstrb  out  C_DATA_WIDTH/8  to converter s_axis_tstrb.
- m_axis_tuser  out  C_TUSER_WIDTH  to converter s_axis_tuser.
- m_axis_tvalid  out  1  to converter s_axis_tvalid.
- m_axis_tlast  out  1  to converter s_axis_tlast.
- m_axis_tready  in  1  from converter s_axis_tready.
- arb_grant  out  C_NUM_PORTS  one-hot current grant; all zero in IDLE.
- arb_busy  out  1  high while in SEND.

## Operation
- Registered state:
  - two-state FSM {IDLE, SEND};
  - grant index g, width clog2(C_NUM_PORTS);
  - priority pointer p, same width.
- IDLE:
  - all s_axis_tready = 0 and m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, g <= the first port with tvalid high, searching p, p+1, …, wrapping modulo C_NUM_PORTS. The FSM then goes to SEND.
  - Otherwise the FSM stays in IDLE.
- SEND, as a combinational pass-through of port g:
  - m_axis_tdata, tstrb, tuser, tvalid and tlast come from slice g; tuser is stamped if enabled.
  - s_axis_tready[g] = m_axis_tready; every other s_axis_tready is 0.
- End of packet: on a cycle in SEND with s_axis_tvalid[g] & m_axis_tready & s_axis_tlast[g]:
  - p <= (g == C_NUM_PORTS-1) ? 0 : g+1;
  - FSM returns to IDLE.
- Transfers are never dropped or reordered, and a packet is never interleaved with another.
- tvalid low during SEND (mid-packet gap) keeps the grant; no timeout.
- Port g deasserting tvalid before tlast is a protocol violation by the source; the grant is held.

## Timing
- Reset (axi_resetn low, asynchronous): FSM = IDLE, g = 0, p = 0.
  - Outputs go low immediately: m_axis_tvalid, m_axis_tlast, all s_axis_tready, arb_grant, arb_busy.
  - m_axis_tdata, tstrb and tuser are don't-care while tvalid is low.
- Reset assertion mid-packet aborts the packet. After reset release, arbitration restarts from port 0; the downstream converter is reset by the same signal.
- Arbitration latency:
  - a request seen in IDLE at edge N puts the first beat on m_axis at cycle N+1;
  - zero additional pipeline latency per beat.
- Exactly one IDLE bubble cycle follows every tlast, even if other ports are waiting.
- Single-beat packet (tvalid & tlast on the first SEND cycle): SEND lasts 1 cycle if m_axis_tready is high.
- m_axis_tready low stalls in place; the beat remains presented unchanged.
- Simultaneous requests from all ports with p = 0 are served in order 0,1,2,…,N-1,0.
- Pointer wrap: after serving port C_NUM_PORTS-1, p = 0.

## Test plan
- Reset state: hold axi_resetn low with all tvalid high → every s_axis_tready = 0, m_axis_tvalid = 0, arb_grant = 0; after release, port 0 is granted first, with arb_grant = 4'b0001 on the following cycle.
- Fairness: ports 0–3 each stream continuous 3-beat packets, m_axis_tready = 1 → output packet order is 0,1,2,3,0,1…; each packet takes 3 cycles plus 1 idle cycle.
- Backpressure: port 2 sends a 5-beat packet while m_axis_tready toggles 1,0,0,1,… → output beats identical and in order, s_axis_tready[2] mirrors m_axis_tready, and no other port's tready rises.
- Skip idle ports: only ports 1 and 3 request, p = 2 → port 3 is served first, then port 1, then p = 2.
- Stamping: C_STAMP_SRC_PORT = 1, port 3 tuser[23:16] = 8'hFF → output tuser[23:16] = 8'h40, while the rest of tuser is passed through unchanged.
- Reset mid-packet: assert axi_resetn low on beat 2 of a 4-beat packet from port 1 → all outputs go low within the same cycle; after release, port 0 (if requesting) is granted first.

Source files
------------

// File: rtl/nf10_axis_rr_arbiter.sv
// nf10_axis_rr_arbiter
// Packet-granular round-robin arbiter. It shares one 64-bit AXI4-Stream master
// between up to 8 requesters, upstream of the 64->256 nf10_axis_converter.
//
// Handshake: a beat moves on any rising edge where tvalid and tready are both
// high. In SEND the granted slave is wired straight through to the master, so
// s_axis_tready[g] is m_axis_tready and m_axis_tvalid is s_axis_tvalid[g].
// In IDLE nothing is accepted or presented. The FSM state is visible on
// arb_busy (SEND) and arb_grant.
// When C_STAMP_SRC_PORT is set, C_TUSER_WIDTH must be at least 24.
module nf10_axis_rr_arbiter #(
  parameter int C_NUM_PORTS      = 4,
  parameter int C_DATA_WIDTH     = 64,
  parameter int C_TUSER_WIDTH    = 128,
  parameter int C_STAMP_SRC_PORT = 0
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]             s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]             s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]          m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic [C_NUM_PORTS-1:0]             arb_grant,
  output logic                               arb_busy
);

  localparam int IW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;
  localparam int SW = C_DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] p_q, p_d;

  logic [IW-1:0] pick;
  logic          pick_found;
  logic          eop;
  int            idx;
  int            gi;

  // Round-robin search: first requesting port at or after the pointer, wrapping.
  always_comb begin
    pick       = p_q;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 0; k < C_NUM_PORTS; k++) begin
      idx = (int'(p_q) + k) % C_NUM_PORTS;
      if (!pick_found && s_axis_tvalid[idx]) begin
        pick       = IW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Last beat of the granted packet is accepted this cycle.
  always_comb begin
    eop = (state_q == ST_SEND) && s_axis_tvalid[g_q] && m_axis_tready && s_axis_tlast[g_q];
  end

  // State, grant and pointer registers; reset restarts arbitration at port 0.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  // Next state: grant on any request in IDLE, rotate priority after tlast.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          g_d     = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (eop) begin
          p_d     = (g_q == IW'(C_NUM_PORTS - 1)) ? '0 : g_q + IW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pass-through of the granted slice in SEND, everything quiet in IDLE.
  always_comb begin
    gi            = int'(g_q);
    arb_busy      = (state_q == ST_SEND);
    arb_grant     = '0;
    m_axis_tdata  = s_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
    m_axis_tstrb  = s_axis_tstrb[gi*SW +: SW];
    m_axis_tuser  = s_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (C_STAMP_SRC_PORT != 0) begin
      m_axis_tuser[23:16] = 8'(8'b1 << (2 * gi));
    end
    if (state_q == ST_SEND) begin
      arb_grant[g_q] = 1'b1;
      m_axis_tvalid  = s_axis_tvalid[g_q];
      m_axis_tlast   = s_axis_tlast[g_q];
    end
    s_axis_tready = arb_grant & {C_NUM_PORTS{m_axis_tready}};
  end

endmodule
